// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one external combinational shifter between two requesters.
// Optional grant counters are compiled in when SHIFT_ARB_STATS_EN is defined.
module shift_arbiter #(
    parameter int DATA_WIDTH         = 8,
    parameter int SHIFT_AMOUNT_WIDTH = $clog2(DATA_WIDTH)
`ifdef SHIFT_ARB_STATS_EN
    ,
    parameter int CNT_WIDTH          = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // reqN_ready is combinational from state/last_id/valids and is high only in
    // IDLE for the granted requester; valid must never wait on ready.
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [DATA_WIDTH-1:0]         req0_data,
    input  logic [SHIFT_AMOUNT_WIDTH-1:0] req0_amt,
    input  logic [1:0]                    req0_op,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [DATA_WIDTH-1:0]         req1_data,
    input  logic [SHIFT_AMOUNT_WIDTH-1:0] req1_amt,
    input  logic [1:0]                    req1_op,
    output logic [DATA_WIDTH-1:0]         sh_data,
    output logic [SHIFT_AMOUNT_WIDTH-1:0] sh_amount,
    output logic [1:0]                    sh_op,
    input  logic [DATA_WIDTH-1:0]         sh_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_id,
    output logic [1:0]                    dbg_state
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]          gnt0_count,
    output logic [CNT_WIDTH-1:0]          gnt1_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                          last_id;
    logic                          grant;
    logic                          gnt_id;
    logic [DATA_WIDTH-1:0]         opnd_data;
    logic [SHIFT_AMOUNT_WIDTH-1:0] opnd_amt;
    logic [1:0]                    opnd_op;
    logic                          opnd_id;
    logic [DATA_WIDTH-1:0]         sel_data;
    logic [SHIFT_AMOUNT_WIDTH-1:0] sel_amt;
    logic [1:0]                    sel_op;

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        gnt_id     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant = 1'b1;
                    // On contention the requester that did not win last time goes first.
                    gnt_id     = (req0_valid && req1_valid) ? ~last_id : req1_valid;
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_data = req0_data;
        sel_amt  = req0_amt;
        sel_op   = req0_op;
        if (gnt_id) begin
            sel_data = req1_data;
            sel_amt  = req1_amt;
            sel_op   = req1_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last_id   <= 1'b1;
            opnd_data <= '0;
            opnd_amt  <= '0;
            opnd_op   <= '0;
            opnd_id   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_id   <= gnt_id;
                opnd_data <= sel_data;
                opnd_amt  <= sel_amt;
                opnd_op   <= sel_op;
                opnd_id   <= gnt_id;
            end
        end
    end

    // The result is captured once, in EXEC, and then held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_data <= sh_result;
            rsp_id   <= opnd_id;
        end
    end

    assign sh_data   = opnd_data;
    assign sh_amount = opnd_amt;
    assign sh_op     = opnd_op;
    assign dbg_state = state;

`ifdef SHIFT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_count <= '0;
            gnt1_count <= '0;
        end else if (grant) begin
            if (gnt_id) gnt1_count <= gnt1_count + 1'b1;
            else        gnt0_count <= gnt0_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter with a behavioural shifter on the sh_* port.
// Define SHIFT_ARB_STATS_EN to also exercise the grant counters (CNT_WIDTH=2).
module tb_shift_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic [AW-1:0] req0_amt = '0, req1_amt = '0;
  logic [1:0]    req0_op = '0, req1_op = '0;
  logic [DW-1:0] sh_data, sh_result;
  logic [AW-1:0] sh_amount;
  logic [1:0]    sh_op;
  logic          rsp_valid, rsp_id;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [1:0]    dbg_state;
`ifdef SHIFT_ARB_STATS_EN
  logic [1:0]    gnt0_count, gnt1_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  shift_arbiter #(
    .DATA_WIDTH(DW),
    .SHIFT_AMOUNT_WIDTH(AW)
`ifdef SHIFT_ARB_STATS_EN
    , .CNT_WIDTH(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .sh_data(sh_data), .sh_amount(sh_amount), .sh_op(sh_op), .sh_result(sh_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .dbg_state(dbg_state)
`ifdef SHIFT_ARB_STATS_EN
    , .gnt0_count(gnt0_count), .gnt1_count(gnt1_count)
`endif
  );

  // Behavioural shifter standing in for the real instance.
  always_comb begin
    case (sh_op)
      2'b00:   sh_result = sh_data << sh_amount;
      2'b01:   sh_result = sh_data >> sh_amount;
      2'b10:   sh_result = DW'($signed(sh_data) >>> sh_amount);
      default: sh_result = sh_data;
    endcase
  end

  // Reference result computed bit by bit from the requested operands.
  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                              input logic [1:0] op);
    logic [DW-1:0] r;
    r = d;
    for (int k = 0; k < DW; k++) begin
      case (op)
        2'b00:   r[k] = (k >= int'(a)) ? d[k - int'(a)] : 1'b0;
        2'b01:   r[k] = (k + int'(a) < DW) ? d[k + int'(a)] : 1'b0;
        2'b10:   r[k] = (k + int'(a) < DW) ? d[k + int'(a)] : d[DW-1];
        default: r[k] = d[k];
      endcase
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) exp_q.push_back({1'b0, ref_shift(req0_data, req0_amt, req0_op)});
      if (req1_valid && req1_ready) exp_q.push_back({1'b1, ref_shift(req1_data, req1_amt, req1_op)});
      if (rsp_valid && rsp_ready) begin
        logic [DW:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got id=%0d data=%h, expected no response", rsp_id, rsp_data);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_id, rsp_data} !== e) begin
            errors++;
            $display("FAIL sb_rsp: got id=%0d data=%h, expected id=%0d data=%h",
                     rsp_id, rsp_data, e[DW], e[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Presents one request and holds it until granted (returns 1 ns after the grant edge).
  task automatic send(input bit id, input logic [DW-1:0] d, input logic [AW-1:0] a,
                      input logic [1:0] op);
    bit got = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_op = op;
    end
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: req%0d ready never seen, expected 1", id);
    end
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Returns at a negedge where rsp_valid is high, or flags a timeout.
  task automatic wait_rsp();
    bit got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid never seen, expected 1");
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (dbg_state == ST_IDLE);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_rsp: got v=%0d id=%0d data=%h, expected 0 0 00", rsp_valid, rsp_id, rsp_data);
    end
    checks++;
    if ({sh_data, sh_amount, sh_op} !== '0) begin
      errors++;
      $display("FAIL reset_sh: got data=%h amt=%0d op=%0d, expected all 0", sh_data, sh_amount, sh_op);
    end
    checks++;
    if ({req0_ready, req1_ready, dbg_state} !== {1'b0, 1'b0, ST_IDLE}) begin
      errors++;
      $display("FAIL reset_idle: got r0=%0d r1=%0d st=%0d, expected 0 0 0", req0_ready, req1_ready, dbg_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sll_latency();
    req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 3'd1; req0_op = 2'b00;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_ready: got %0d, expected 1", req0_ready);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, dbg_state, sh_data} !== {1'b0, ST_EXEC, 8'h81}) begin
      errors++;
      $display("FAIL exec_cycle: got v=%0d st=%0d sh_data=%h, expected 0 1 81", rsp_valid, dbg_state, sh_data);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 8'h02}) begin
      errors++;
      $display("FAIL sll_rsp: got v=%0d id=%0d data=%h, expected 1 0 02", rsp_valid, rsp_id, rsp_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ops();
    logic [1:0]    ops[3]  = '{2'b10, 2'b01, 2'b11};
    logic [DW-1:0] exps[3] = '{8'hE4, 8'h24, 8'h90};
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'h90, 3'd2, ops[i]);
      wait_rsp();
      checks++;
      if ({rsp_id, rsp_data} !== {1'b1, exps[i]}) begin
        errors++;
        $display("FAIL op%0d: got id=%0d data=%h, expected 1 %h", ops[i], rsp_id, rsp_data, exps[i]);
      end
      @(posedge clk);
      #1;
    end
    // Random operands through the scoreboard only.
    for (int i = 0; i < 6; i++)
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)));
    wait_drain();
  endtask

  task automatic test_contention();
    bit exp_order[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int n = 0;
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h11; req0_amt = 3'd1; req0_op = 2'b00;
    req1_valid = 1'b1; req1_data = 8'hA6; req1_amt = 3'd3; req1_op = 2'b10;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        checks++;
        if (req0_ready && req1_ready) begin
          errors++;
          $display("FAIL double_grant: both readies high, expected one");
        end else if (req1_ready !== exp_order[n]) begin
          errors++;
          $display("FAIL grant_order[%0d]: got req%0d, expected req%0d", n, req1_ready, exp_order[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL grant_count: got %0d grants, expected 4", n);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    send(1'b0, 8'h0F, 3'd3, 2'b00);
    wait_rsp();
    @(posedge clk);
    #1;
    req1_valid = 1'b1; req1_data = 8'h5A; req1_amt = 3'd0; req1_op = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready} !== {1'b1, 1'b0, 8'h78, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%0d id=%0d data=%h r0=%0d r1=%0d, expected 1 0 78 0 0",
                 c, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready);
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL resp_cycle_ready: got %0d, expected 0", req1_ready);
    end
    @(negedge clk);
    checks++;
    if ({dbg_state, req1_ready} !== {ST_IDLE, 1'b1}) begin
      errors++;
      $display("FAIL idle_after_accept: got st=%0d r1=%0d, expected 0 1", dbg_state, req1_ready);
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    send(1'b0, 8'h33, 3'd1, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, sh_data, sh_amount, sh_op, dbg_state} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got v=%0d sh=%h/%0d/%0d st=%0d, expected all 0",
               rsp_valid, sh_data, sh_amount, sh_op, dbg_state);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_data = 8'hC3; req0_amt = 3'd4; req0_op = 2'b01;
    req1_valid = 1'b1; req1_data = 8'h3C; req1_amt = 3'd4; req1_op = 2'b00;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_grant: got r0=%0d r1=%0d, expected 1 0", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();
  endtask

`ifdef SHIFT_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    @(negedge clk);
    checks++;
    if ({gnt0_count, gnt1_count} !== 4'h0) begin
      errors++;
      $display("FAIL cnt_reset: got %0d/%0d, expected 0/0", gnt0_count, gnt1_count);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(1'b0, 8'(i), 3'd1, 2'b00);
    wait_drain();
    @(negedge clk);
    checks++;
    if ({gnt0_count, gnt1_count} !== {2'd1, 2'd0}) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d/%0d, expected 1/0", gnt0_count, gnt1_count);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_sll_latency();
    test_ops();
    test_contention();
    test_backpressure();
    test_reset_mid();
`ifdef SHIFT_ARB_STATS_EN
    test_stats();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
